// File: rtl/div_ctrl_pkg.sv
// Shared defines for the EX-stage divide controller.
//   REG_DATA_WIDTH    : architectural register width
//   DOUBLE_DATA_WIDTH : width of the {remainder, quotient} divider result
//   divc_state_e      : controller state encodings (DIVC_IDLE/BUSY/DONE)
package div_ctrl_pkg;

  localparam int REG_DATA_WIDTH    = 32;
  localparam int DOUBLE_DATA_WIDTH = 2 * REG_DATA_WIDTH;

  typedef enum logic [1:0] {
    DIVC_IDLE = 2'd0,
    DIVC_BUSY = 2'd1,
    DIVC_DONE = 2'd2
  } divc_state_e;

endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequences a multi-cycle divider from the EX stage.
// Latches operands on a DIV/DIVU request, holds the pipeline while the divider
// runs, writes {remainder, quotient} into HI/LO, and aborts on flush or when a
// watchdog expires.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   div_req_in/div_signed_in : EX holds DIV (signed=1) or DIVU (signed=0)
//   op1_in/op2_in            : dividend / divisor
//   flush_in                 : pipeline flush / exception
//   stall_req_out            : hold the pipeline (combinational)
//   div_start_out/div_cancel_out/div_signed_out, div_dived_out/div_div_out
//                            : divider control and operands (registered)
//   div_res_in, div_ready_in : divider result {rem, quo} and valid
//   hilo_we_out, hi_out, lo_out : HI/LO write strobe and data
//   div_err_out              : one-cycle pulse on watchdog timeout
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW      = REG_DATA_WIDTH,
  parameter int TIMEOUT = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_req_in,
  input  logic            div_signed_in,
  input  logic [DW-1:0]   op1_in,
  input  logic [DW-1:0]   op2_in,
  input  logic            flush_in,
  output logic            stall_req_out,
  output logic            div_start_out,
  output logic            div_cancel_out,
  output logic            div_signed_out,
  output logic [DW-1:0]   div_dived_out,
  output logic [DW-1:0]   div_div_out,
  input  logic [2*DW-1:0] div_res_in,
  input  logic            div_ready_in,
  output logic            hilo_we_out,
  output logic [DW-1:0]   hi_out,
  output logic [DW-1:0]   lo_out,
  output logic            div_err_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  divc_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          start_nxt, cancel_nxt, signed_nxt, we_nxt, err_nxt;
  logic [DW-1:0] dived_nxt, div_nxt, hi_nxt, lo_nxt;
  logic          accept;

  assign accept = div_req_in & ~flush_in;

  // BUSY term is masked by rst so the pipeline is released while reset is held,
  // even before the reset edge has moved the FSM back to IDLE.
  assign stall_req_out = ((state == DIVC_IDLE) & accept) |
                         ((state == DIVC_BUSY) & ~rst);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    start_nxt  = div_start_out;
    cancel_nxt = 1'b0;
    err_nxt    = 1'b0;
    we_nxt     = 1'b0;
    signed_nxt = div_signed_out;
    dived_nxt  = div_dived_out;
    div_nxt    = div_div_out;
    hi_nxt     = hi_out;
    lo_nxt     = lo_out;
    case (state)
      DIVC_IDLE: begin
        if (accept) begin
          dived_nxt  = op1_in;
          div_nxt    = op2_in;
          signed_nxt = div_signed_in;
          start_nxt  = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = DIVC_BUSY;
        end
      end
      DIVC_BUSY: begin
        // flush beats a same-cycle result: the instruction is being killed
        if (flush_in) begin
          cancel_nxt = 1'b1;
          start_nxt  = 1'b0;
          state_nxt  = DIVC_IDLE;
        end else if (div_ready_in) begin
          hi_nxt    = div_res_in[2*DW-1:DW];
          lo_nxt    = div_res_in[DW-1:0];
          we_nxt    = 1'b1;
          start_nxt = 1'b0;
          state_nxt = DIVC_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          cancel_nxt = 1'b1;
          err_nxt    = 1'b1;
          start_nxt  = 1'b0;
          state_nxt  = DIVC_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DIVC_DONE: begin
        // request still visible here belongs to the retiring instruction
        state_nxt = DIVC_IDLE;
      end
      default: state_nxt = DIVC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= DIVC_IDLE;
      cnt            <= '0;
      div_start_out  <= 1'b0;
      div_cancel_out <= 1'b0;
      div_signed_out <= 1'b0;
      div_dived_out  <= '0;
      div_div_out    <= '0;
      hilo_we_out    <= 1'b0;
      div_err_out    <= 1'b0;
      hi_out         <= '0;
      lo_out         <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      div_start_out  <= start_nxt;
      div_cancel_out <= cancel_nxt;
      div_signed_out <= signed_nxt;
      div_dived_out  <= dived_nxt;
      div_div_out    <= div_nxt;
      hilo_we_out    <= we_nxt;
      div_err_out    <= err_nxt;
      hi_out         <= hi_nxt;
      lo_out         <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_in, div_signed_in, flush_in;
  logic [31:0] op1_in, op2_in;
  logic        stall_req_out, div_start_out, div_cancel_out, div_signed_out;
  logic [31:0] div_dived_out, div_div_out;
  logic [63:0] div_res_in;
  logic        div_ready_in;
  logic        hilo_we_out, div_err_out;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic        err_ok = 1'b0;
  logic        prev_ready = 1'b0;

  // divider stub controls
  int   stub_lat = 2;
  logic never_ready = 1'b0;
  int   stub_st = 0;
  int   stub_cnt = 0;

  div_ctrl #(.DW(32), .TIMEOUT(48)) dut (
    .clk(clk), .rst(rst),
    .div_req_in(div_req_in), .div_signed_in(div_signed_in),
    .op1_in(op1_in), .op2_in(op2_in), .flush_in(flush_in),
    .stall_req_out(stall_req_out),
    .div_start_out(div_start_out), .div_cancel_out(div_cancel_out),
    .div_signed_out(div_signed_out),
    .div_dived_out(div_dived_out), .div_div_out(div_div_out),
    .div_res_in(div_res_in), .div_ready_in(div_ready_in),
    .hilo_we_out(hilo_we_out), .hi_out(hi_out), .lo_out(lo_out),
    .div_err_out(div_err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MIPS-style divide: {remainder, quotient}, truncating toward zero; x/0 -> 0,0
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Behavioural divider sibling: starts when it sees start, answers after
  // stub_lat+1 cycles with a one-cycle ready, rearms only once start drops.
  always @(posedge clk) begin
    div_ready_in <= 1'b0;
    if (rst || div_cancel_out) stub_st <= 0;
    else case (stub_st)
      0: if (div_start_out && !never_ready) begin stub_cnt <= stub_lat; stub_st <= 1; end
      1: if (!div_start_out) stub_st <= 0;
         else if (stub_cnt == 0) begin
           div_ready_in <= 1'b1;
           div_res_in   <= ref_div(div_dived_out, div_div_out, div_signed_out);
           stub_st      <= 2;
         end else stub_cnt <= stub_cnt - 1;
      default: if (!div_start_out) stub_st <= 0;
    endcase
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && hilo_we_out) begin
      chk("we_one_after_ready", {63'd0, prev_ready}, 64'd1);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: hi=%0h lo=%0h", hi_out, lo_out);
      end else begin
        e = exp_q.pop_front();
        chk("hi", {32'd0, hi_out}, {32'd0, e[63:32]});
        chk("lo", {32'd0, lo_out}, {32'd0, e[31:0]});
      end
    end
    if (div_err_out && !err_ok) begin
      checks++; failures++;
      $display("FAIL unexpected_err: got 1 expected 0");
    end
    prev_ready <= div_ready_in;
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int lat);
    int n;
    exp_q.push_back(ref_div(a, b, s));
    stub_lat = lat;
    @(negedge clk);
    div_req_in = 1'b1; div_signed_in = s; op1_in = a; op2_in = b;
    #1 chk("stall_on_req", {63'd0, stall_req_out}, 64'd1);
    @(negedge clk); #1;
    chk("start_after_accept", {63'd0, div_start_out}, 64'd1);
    chk("dived_reg", {32'd0, div_dived_out}, {32'd0, a});
    chk("div_reg", {32'd0, div_div_out}, {32'd0, b});
    chk("signed_reg", {63'd0, div_signed_out}, {63'd0, s});
    n = 0;
    while (stall_req_out && n < 200) begin @(negedge clk); #1; n++; end
    if (n >= 200) bound_fail("done_wait");
    chk("we_in_done", {63'd0, hilo_we_out}, 64'd1);
    chk("start_low_done", {63'd0, div_start_out}, 64'd0);
    @(negedge clk);
    div_req_in = 1'b0;
    #1 chk("no_restart_stall", {63'd0, stall_req_out}, 64'd0);
    chk("no_restart_start", {63'd0, div_start_out}, 64'd0);
  endtask

  initial begin
    int n, a0;
    logic [31:0] ra, rb;
    rst = 1'b1; div_req_in = 1'b0; div_signed_in = 1'b0; flush_in = 1'b0;
    op1_in = '0; op2_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", {63'd0, div_start_out}, 64'd0);
    chk("rst_cancel", {63'd0, div_cancel_out}, 64'd0);
    chk("rst_we", {63'd0, hilo_we_out}, 64'd0);
    chk("rst_err", {63'd0, div_err_out}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    chk("rst_ops", {div_dived_out, div_div_out}, 64'd0);
    chk("rst_stall_noreq", {63'd0, stall_req_out}, 64'd0);
    div_req_in = 1'b1;
    #1 chk("rst_stall_req_idle", {63'd0, stall_req_out}, 64'd1);
    div_req_in = 1'b0;
    @(negedge clk); rst = 1'b0;

    // directed
    run_div(32'd100, 32'd7, 1'b0, 3);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 5);
    run_div(32'd1234, 32'd0, 1'b0, 1);

    // request with flush in IDLE must not start
    @(negedge clk);
    div_req_in = 1'b1; flush_in = 1'b1; op1_in = 32'd8; op2_in = 32'd2;
    #1 chk("idle_flush_stall", {63'd0, stall_req_out}, 64'd0);
    @(negedge clk); div_req_in = 1'b0; flush_in = 1'b0;
    #1 chk("idle_flush_nostart", {63'd0, div_start_out}, 64'd0);

    // flush at BUSY cycle 10
    stub_lat = 30;
    @(negedge clk);
    div_req_in = 1'b1; div_signed_in = 1'b0; op1_in = 32'd77; op2_in = 32'd5;
    repeat (10) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    div_req_in = 1'b0; flush_in = 1'b0;
    #1 chk("flush_cancel", {63'd0, div_cancel_out}, 64'd1);
    chk("flush_no_we", {63'd0, hilo_we_out}, 64'd0);
    chk("flush_start_low", {63'd0, div_start_out}, 64'd0);
    chk("flush_idle_stall", {63'd0, stall_req_out}, 64'd0);
    @(negedge clk);
    #1 chk("cancel_one_cycle", {63'd0, div_cancel_out}, 64'd0);
    run_div(32'd9, 32'd3, 1'b0, 2);

    // flush in the same cycle as ready: flush wins
    stub_lat = 3;
    @(negedge clk);
    div_req_in = 1'b1; div_signed_in = 1'b1; op1_in = 32'd50; op2_in = 32'd6;
    n = 0;
    @(negedge clk); #1;
    while (!div_ready_in && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) bound_fail("ready_wait");
    flush_in = 1'b1;
    @(negedge clk);
    div_req_in = 1'b0; flush_in = 1'b0;
    #1 chk("flush_vs_ready_cancel", {63'd0, div_cancel_out}, 64'd1);
    chk("flush_vs_ready_no_we", {63'd0, hilo_we_out}, 64'd0);
    chk("hi_held", {hi_out, lo_out}, {32'd0, 32'd3});

    // watchdog
    never_ready = 1'b1; err_ok = 1'b1;
    @(negedge clk);
    div_req_in = 1'b1; div_signed_in = 1'b0; op1_in = 32'd5; op2_in = 32'd1;
    @(negedge clk);
    a0 = cyc; n = 0;
    #1;
    while (!div_err_out && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) bound_fail("timeout_wait");
    chk("timeout_cycles", 64'(cyc - a0), 64'd48);
    chk("timeout_cancel", {63'd0, div_cancel_out}, 64'd1);
    chk("timeout_no_we", {63'd0, hilo_we_out}, 64'd0);
    div_req_in = 1'b0;
    @(negedge clk);
    #1 chk("err_one_cycle", {63'd0, div_err_out}, 64'd0);
    chk("timeout_idle", {63'd0, stall_req_out}, 64'd0);
    never_ready = 1'b0; err_ok = 1'b0;

    // reset mid-BUSY, then back-to-back divides
    stub_lat = 20;
    @(negedge clk);
    div_req_in = 1'b1; div_signed_in = 1'b0; op1_in = 32'd50; op2_in = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1; div_req_in = 1'b0;
    #1 chk("rst_busy_stall", {63'd0, stall_req_out}, 64'd0);
    @(negedge clk);
    #1 chk("rst_busy_start", {63'd0, div_start_out}, 64'd0);
    chk("rst_busy_hilo", {hi_out, lo_out}, 64'd0);
    chk("rst_busy_ops", {div_dived_out, div_div_out}, 64'd0);
    chk("rst_busy_flags", {60'd0, div_cancel_out, hilo_we_out, div_err_out, div_signed_out}, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_div(32'd1000, 32'd33, 1'b0, 0);
    run_div(32'hFFFFFF00, 32'd7, 1'b1, 4);

    // randomized
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 300));
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      run_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 10));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32 (REG_DATA_WIDTH): operand width.
REQ-002 SHALL have parameter TIMEOUT, default 48: maximum BUSY cycles before abort.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: synchronous reset, active high.
REQ-006 SHALL have port div_req_in, input, 1: EX stage holds a DIV/DIVU.
REQ-007 SHALL have port div_signed_in, input, 1: 1 = DIV, 0 = DIVU.
REQ-008 SHALL have port op1_in, input, DW: dividend.
REQ-009 SHALL have port op2_in, input, DW: divisor.
REQ-010 SHALL have port flush_in, input, 1: pipeline flush/exception.
REQ-011 SHALL have port stall_req_out, output, 1: hold the pipeline.
REQ-012 SHALL have ports div_start_out, div_cancel_out and div_signed_out, output, 1 each: drive the divider.
REQ-013 SHALL have ports div_dived_out and div_div_out, output, DW: divider operands.
REQ-014 SHALL have port div_res_in, input, 2*DW: {remainder, quotient} from the divider.
REQ-015 SHALL have port div_ready_in, input, 1: divider result valid.
REQ-016 SHALL have ports hilo_we_out, output, 1; hi_out, output, DW; lo_out, output, DW: HI/LO write.
REQ-017 SHALL have port div_err_out, output, 1: one-cycle pulse on timeout.

Function
REQ-018 SHALL implement states IDLE, BUSY and DONE.
REQ-019 IDLE: on div_req_in & !flush_in, SHALL register op1/op2/signed into the div_*_out ports, set div_start_out=1, clear the watchdog counter and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-020 stall_req_out SHALL be combinational = (IDLE & div_req_in & !flush_in) | BUSY.
REQ-021 BUSY: div_start_out and the operands SHALL be held stable, and the watchdog SHALL increment each cycle.
REQ-022 BUSY & div_ready_in: SHALL register hi_out=div_res_in[2DW-1:DW] and lo_out=div_res_in[DW-1:0], pulse hilo_we_out for exactly one cycle, clear div_start_out and go to DONE.
REQ-023 BUSY & flush_in SHALL take priority over div_ready_in: pulse div_cancel_out for one cycle, clear div_start_out, suppress hilo_we_out and go to IDLE.
REQ-024 BUSY & counter == TIMEOUT-1 without ready: SHALL pulse div_cancel_out and div_err_out, clear div_start_out, suppress the write and go to IDLE.
REQ-025 DONE: SHALL last exactly one cycle with stall_req_out=0, ignore div_req_in (the same instruction retires), then go to IDLE.
REQ-026 Latency: hilo_we_out SHALL assert one cycle after div_ready_in, and stall SHALL release the cycle after that.
REQ-027 Back-to-back divides SHALL be accepted from IDLE no earlier than the cycle after DONE; the divider has returned to idle by then because start was low during DONE.
REQ-028 Divide-by-zero SHALL NOT be special-cased: the divider result (0/0) is written as-is.
REQ-029 hi_out and lo_out SHALL hold their value between writes.

Reset
REQ-030 rst SHALL force, at the next edge: state=IDLE, div_start_out=0, div_cancel_out=0, hilo_we_out=0, div_err_out=0, hi_out=0, lo_out=0, operand outputs=0, counter=0.
REQ-031 Reset mid-BUSY SHALL discard the operation with no hilo_we_out, and the divider SHALL see start drop.
REQ-032 stall_req_out SHALL read 0 during reset unless div_req_in is high in IDLE.

Structure
REQ-033 REG_DATA_WIDTH, DOUBLE_DATA_WIDTH and the DIVC_IDLE/DIVC_BUSY/DIVC_DONE encodings SHALL live in the shared defines package.
REQ-034 SHALL contain no sub-module; the divider SHALL remain a sibling instance in the EX top level.

Verification
REQ-035 Unsigned 100/7 with divider attached -> hi=2, lo=14, one hilo_we pulse, stall high from the request cycle until DONE.
REQ-036 Signed 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 Divisor 0 -> hi=0, lo=0, write occurs, no err.
REQ-038 flush_in at BUSY cycle 10 -> div_cancel pulse, no write, IDLE; a fresh 9/3 next -> lo=3, hi=0.
REQ-039 Divider stubbed never-ready, TIMEOUT=48 -> cancel + err pulse exactly 48 cycles after entering BUSY.
REQ-040 rst asserted mid-BUSY, then two back-to-back divides -> clean reset values, both results correct, DONE cycle never restarts.
